spi_reg_controller: RTL and testbench

//  SPI mode-0 slave (CPOL=0, CPHA=0) command controller that configures the camera datapath.

---
 rtl/spi_reg_controller.sv | 167 ++++++++++++++++
 tb/tb_spi_reg_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_controller.sv
// rtl/spi_reg_controller.sv - SPI mode-0 slave decoding command/data bytes into a register bank
// Optional feature: define SPI_BURST_EN for address auto-increment across data bytes.
module spi_reg_controller #(
    parameter int         NREGS   = 16,
    parameter logic [7:0] ID_BYTE = 8'hAB,
    localparam int        ADDR_W  = $clog2(NREGS)
) (
    input  logic                 main_clock,
    input  logic                 reset_n,
    input  logic                 sck,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 so,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    localparam logic [7:0] NREGS_B = 8'(NREGS);

    logic              sck_s1_q, sck_s2_q, sck_prev_q;
    logic              cs_s1_q, cs_s2_q, cs_prev_q;
    logic              mosi_s1_q, mosi_s2_q;
    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        rx_q;
    logic [7:0]        tx_q;
    logic              rw_q;
    logic [6:0]        addr_q;
    logic              wr_pend_q;
    logic [7:0]        wr_data_q;
    logic [ADDR_W-1:0] wr_idx_q;
    logic [7:0]        regs_q [NREGS];
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              busy_q;

    logic       sck_rise, sck_fall, cs_fall, cs_rise, byte_done;
    logic [7:0] rx_d;
    logic [7:0] rd_cmd_d;

    function automatic logic addr_ok(input logic [6:0] a);
        return {1'b0, a} < NREGS_B;
    endfunction

    assign sck_rise  = sck_s2_q & ~sck_prev_q;
    assign sck_fall  = ~sck_s2_q & sck_prev_q;
    assign cs_fall   = ~cs_s2_q & cs_prev_q;
    assign cs_rise   = cs_s2_q & ~cs_prev_q;
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        rx_d     = {rx_q, mosi_s2_q};
        rd_cmd_d = addr_ok(rx_d[6:0]) ? regs_q[rx_d[ADDR_W-1:0]] : 8'h00;
    end

`ifdef SPI_BURST_EN
    localparam bit NREGS_POW2 = ((NREGS & (NREGS - 1)) == 0);
    logic [6:0] addr_next_d;
    logic [7:0] rd_next_d;

    // Power-of-two banks wrap to 0; otherwise park on an invalid address.
    always_comb begin
        if (!addr_ok(addr_q))
            addr_next_d = addr_q;
        else if ({1'b0, addr_q} == NREGS_B - 8'd1)
            addr_next_d = NREGS_POW2 ? 7'd0 : 7'(NREGS);
        else
            addr_next_d = addr_q + 7'd1;
        rd_next_d = addr_ok(addr_next_d) ? regs_q[addr_next_d[ADDR_W-1:0]] : 8'h00;
    end
`endif

    // cs synchronizer resets low so a reset released mid-frame waits for a real cs high-to-low.
    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_s1_q    <= 1'b0;
            sck_s2_q    <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_s1_q     <= 1'b0;
            cs_s2_q     <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= ID_BYTE;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            wr_pend_q   <= 1'b0;
            wr_data_q   <= 8'h00;
            wr_idx_q    <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
        end else begin
            sck_s1_q   <= sck;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            cs_s1_q    <= cs;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            mosi_s1_q  <= mosi;
            mosi_s2_q  <= mosi_s1_q;

            wr_pend_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            if (wr_pend_q) begin
                regs_q[wr_idx_q] <= wr_data_q;
                wr_strobe_q      <= 1'b1;
                wr_addr_q        <= wr_idx_q;
            end

            if (state_q == IDLE) begin
                if (cs_fall) begin
                    state_q   <= CMD;
                    bit_cnt_q <= 3'd0;
                    tx_q      <= ID_BYTE;
                    busy_q    <= 1'b1;
                end
            end else if (sck_rise) begin
                rx_q      <= rx_d[6:0];
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (byte_done && state_q == CMD) begin
                    rw_q    <= rx_d[7];
                    addr_q  <= rx_d[6:0];
                    state_q <= DATA;
                    tx_q    <= rx_d[7] ? rd_cmd_d : 8'h00;
                end else if (byte_done && state_q == DATA) begin
                    if (!rw_q && addr_ok(addr_q)) begin
                        wr_pend_q <= 1'b1;
                        wr_data_q <= rx_d;
                        wr_idx_q  <= addr_q[ADDR_W-1:0];
                    end
`ifdef SPI_BURST_EN
                    addr_q <= addr_next_d;
                    tx_q   <= rw_q ? rd_next_d : 8'h00;
`else
                    state_q <= DONE;
                    tx_q    <= 8'h00;
`endif
                end
            end else if (sck_fall && bit_cnt_q != 3'd0) begin
                // The falling edge right after a byte boundary keeps the freshly loaded MSB.
                tx_q <= {tx_q[6:0], 1'b0};
            end

            if (cs_rise) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign so        = cs ? 1'bz : tx_q[7];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_spi_reg_controller.sv
// tb/tb_spi_reg_controller.sv - scoreboard bench for spi_reg_controller with randomized SPI traffic
`timescale 1ns/1ps
module tb_spi_reg_controller;
    localparam int         NREGS = 16;
    localparam logic [7:0] ID    = 8'hAB;
    localparam int         HALF  = 50;

    typedef logic [7:0] bq_t [$];
    typedef struct packed { logic chk; logic [7:0] val; } mexp_t;
    typedef struct packed { logic [3:0] a; logic [7:0] d; } sexp_t;

    logic main_clock = 1'b0;
    logic reset_n = 1'b0;
    logic sck = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;
    wire  so;
    logic [8*NREGS-1:0] regs_flat;
    logic wr_strobe;
    logic [3:0] wr_addr;
    logic busy;

    int checks = 0;
    int errors = 0;
    mexp_t exp_miso[$];
    sexp_t exp_strobe[$];
    logic [7:0] mr [NREGS];

    spi_reg_controller #(.NREGS(NREGS), .ID_BYTE(ID)) dut (
        .main_clock(main_clock),
        .reset_n(reset_n),
        .sck(sck),
        .cs(cs),
        .mosi(mosi),
        .so(so),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_addr(wr_addr),
        .busy(busy)
    );

    always #5 main_clock = ~main_clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) v[8*i +: 8] = mr[i];
        return v;
    endfunction

    always @(negedge main_clock) begin
        sexp_t e;
        if (reset_n && wr_strobe) begin
            if (exp_strobe.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual addr=%0d required no strobe", wr_addr);
            end else begin
                e = exp_strobe.pop_front();
                chk("strobe_addr", 128'(wr_addr), 128'(e.a));
                chk("strobe_reg_value", 128'(regs_flat[8*e.a +: 8]), 128'(e.d));
            end
        end
    end

    int mbit = 0;
    logic [7:0] msh = 8'h00;
    always @(posedge sck or posedge cs) begin
        mexp_t e;
        if (cs) begin
            mbit = 0;
        end else begin
            msh = {msh[6:0], so};
            mbit++;
            if (mbit == 8) begin
                mbit = 0;
                if (exp_miso.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_miso_byte actual=%0h required none", msh);
                end else begin
                    e = exp_miso.pop_front();
                    if (e.chk) chk("miso_byte", 128'(msh), 128'(e.val));
                end
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            mosi = b[i];
            #HALF sck = 1'b1;
            #HALF sck = 1'b0;
        end
    endtask

    task automatic spi_xfer(input bq_t bytes, input int last_bits);
        cs = 1'b0;
        #(2*HALF);
        chk("busy_in_xfer", 128'(busy), 128'(1));
        foreach (bytes[k]) send_bits(bytes[k], (k == bytes.size() - 1) ? last_bits : 8);
        #HALF cs = 1'b1;
        #(2*HALF);
        chk("busy_after_xfer", 128'(busy), 128'(0));
    endtask

    task automatic issue(input logic [7:0] cmd, input bq_t data);
        int a;
        bq_t all;
        a = int'(cmd[6:0]);
        exp_miso.push_back('{1'b1, ID});
        all.push_back(cmd);
        foreach (data[i]) begin
            int ai;
            logic active;
`ifdef SPI_BURST_EN
            active = 1'b1;
            ai = (a < NREGS) ? (a + i) % NREGS : a;
`else
            active = (i == 0);
            ai = a;
`endif
            if (cmd[7]) begin
                if (active && ai < NREGS) exp_miso.push_back('{1'b1, mr[ai]});
                else exp_miso.push_back('{1'b1, 8'h00});
            end else begin
                exp_miso.push_back('{1'b0, 8'h00});
                if (active && ai < NREGS) begin
                    mr[ai] = data[i];
                    exp_strobe.push_back('{4'(ai), data[i]});
                end
            end
            all.push_back(data[i]);
        end
        spi_xfer(all, 8);
        chk("strobes_outstanding", 128'(exp_strobe.size()), 128'(0));
        chk("miso_outstanding", 128'(exp_miso.size()), 128'(0));
        chk("regs_flat", regs_flat, model_vec());
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t d;
        for (int i = 0; i < NREGS; i++) mr[i] = 8'h00;
        #40 reset_n = 1'b1;
        #20;
        chk("reset_regs", regs_flat, 128'(0));
        chk("reset_strobe", 128'(wr_strobe), 128'(0));
        chk("reset_wr_addr", 128'(wr_addr), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));

        d = {8'h00};
        issue(8'h80, d);
        d = {8'h5A};
        issue(8'h03, d);
        chk("reg3_value", 128'(regs_flat[31:24]), 128'(8'h5A));
        d = {8'h00};
        issue(8'h83, d);

        d = {8'h77};
        issue(8'h20, d);
        d = {8'h00};
        issue(8'hA0, d);

        exp_miso.push_back('{1'b1, ID});
        d = {8'h05, 8'hFF};
        spi_xfer(d, 4);
        chk("partial_no_strobe", 128'(exp_strobe.size()), 128'(0));
        chk("partial_regs", regs_flat, model_vec());
        d = {8'h00};
        issue(8'h85, d);

        exp_miso.push_back('{1'b1, ID});
        cs = 1'b0;
        #(2*HALF);
        send_bits(8'h05, 8);
        send_bits(8'hC3, 4);
        reset_n = 1'b0;
        #30;
        chk("midreset_regs", regs_flat, 128'(0));
        chk("midreset_busy", 128'(busy), 128'(0));
        chk("midreset_strobe", 128'(wr_strobe), 128'(0));
        reset_n = 1'b1;
        for (int i = 0; i < NREGS; i++) mr[i] = 8'h00;
        #50 cs = 1'b1;
        #(2*HALF);
        chk("midreset_miso_outstanding", 128'(exp_miso.size()), 128'(0));
        d = {8'hC3};
        issue(8'h01, d);
        d = {8'h00};
        issue(8'h81, d);

`ifdef SPI_BURST_EN
        d = {8'h11, 8'h22, 8'h33};
        issue(8'h0E, d);
        d = {8'h00, 8'h00, 8'h00};
        issue(8'h8E, d);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [7:0] cmd;
            int nb;
            cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 19))};
            nb = $urandom_range(1, 3);
            d = {};
            for (int j = 0; j < nb; j++) d.push_back(8'($urandom));
            issue(cmd, d);
        end

        chk("final_regs", regs_flat, model_vec());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
